// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants for the two-floor elevator controller
package elevator_pkg;

    localparam int N_BTN                   = 4;
    localparam int BTN_UP                  = 0;
    localparam int BTN_DOWN                = 1;
    localparam int BTN_TO_ONE              = 2;
    localparam int BTN_TO_TWO              = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/elevator_request_conditioner_if.sv
// rtl/elevator_request_conditioner_if.sv - button inputs and conditioned request outputs
interface elevator_request_conditioner_if;
    import elevator_pkg::*;

    btn_vec_t btn_raw;
    logic     start_stop_raw;
    btn_vec_t req_clr;
    btn_vec_t req_pending;
    btn_vec_t req_pulse;
    logic     run;

    // Drives the raw buttons and clears, observes the conditioned requests
    modport master (
        output btn_raw, start_stop_raw, req_clr,
        input  req_pending, req_pulse, run
    );

    // The conditioner itself
    modport slave (
        input  btn_raw, start_stop_raw, req_clr,
        output req_pending, req_pulse, run
    );

endinterface

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - synchroniser, debounce counter and rising-edge strobe for one button
module debounce_cell
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_rise;

    // Two-flop synchroniser, then count consecutive differing samples; the
    // counter is cleared at the terminal count so it can never wrap. The rise
    // strobe is registered on the same edge that stable goes high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_rise   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/elevator_request_conditioner.sv
// rtl/elevator_request_conditioner.sv - run toggle and per-button pending/pulse request latches
module elevator_request_conditioner
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                          clk_50mhz,
    input  logic                          rst,
    elevator_request_conditioner_if.slave bus
);

    btn_vec_t w_btn_rise;
    logic     w_ss_rise;
    btn_vec_t w_pulse;
    logic     w_run_fall;
    btn_vec_t w_pending_nxt;

    logic     r_run;
    btn_vec_t r_pending;
    btn_vec_t r_pulse;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .i_clk  (clk_50mhz),
            .i_rst  (rst),
            .i_raw  (bus.btn_raw[g]),
            .o_rise (w_btn_rise[g])
        );
    end

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_cell (
        .i_clk  (clk_50mhz),
        .i_rst  (rst),
        .i_raw  (bus.start_stop_raw),
        .o_rise (w_ss_rise)
    );

    // Presses are only accepted while running; a new press beats a clear, and
    // stopping the system drops every outstanding request.
    always_comb begin
        w_pulse       = w_btn_rise & {N_BTN{r_run}};
        w_run_fall    = w_ss_rise & r_run;
        w_pending_nxt = r_pending;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_run_fall) begin
                w_pending_nxt[i] = 1'b0;
            end else if (w_pulse[i]) begin
                w_pending_nxt[i] = 1'b1;
            end else if (bus.req_clr[i]) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    // Register run, pending requests and the one-cycle request strobes
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            r_run     <= r_run ^ w_ss_rise;
            r_pending <= w_pending_nxt;
            r_pulse   <= w_pulse;
        end
    end

    assign bus.run         = r_run;
    assign bus.req_pending = r_pending;
    assign bus.req_pulse   = r_pulse;

endmodule

// File: tb/tb_elevator_request_conditioner.sv
// tb/tb_elevator_request_conditioner.sv - self-checking bench for elevator_request_conditioner
module tb_elevator_request_conditioner;

    localparam int D = 4;

    logic clk;
    logic rst;

    elevator_request_conditioner_if bus ();

    elevator_request_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a button's accepted level flips once its last D
    // synchronised samples (raw samples two edges old) all disagree with it;
    // request bookkeeping follows one edge after that flip.
    logic [63:0] m_hist [5];
    logic [4:0]  m_stable;
    logic [4:0]  m_rise;
    logic        m_run;
    logic [3:0]  m_pend;
    logic [3:0]  m_pulse;

    int         first_pulse_k;
    logic [3:0] first_pulse_v;
    int         first_run_k;
    int         pulse_cnt [4];

    task automatic model_edge(input logic r, input logic [4:0] raw, input logic [3:0] clr);
        logic [3:0] p;
        logic       fall;
        logic [4:0] new_rise;
        logic       all_diff;
        if (r) begin
            for (int i = 0; i < 5; i++) m_hist[i] = '0;
            m_stable = '0;
            m_rise   = '0;
            m_run    = 1'b0;
            m_pend   = '0;
            m_pulse  = '0;
        end else begin
            p    = m_rise[3:0] & {4{m_run}};
            fall = m_rise[4] & m_run;
            for (int i = 0; i < 4; i++) begin
                if (fall)        m_pend[i] = 1'b0;
                else if (p[i])   m_pend[i] = 1'b1;
                else if (clr[i]) m_pend[i] = 1'b0;
            end
            m_pulse  = p;
            m_run    = m_run ^ m_rise[4];
            new_rise = '0;
            for (int i = 0; i < 5; i++) begin
                m_hist[i] = {m_hist[i][62:0], raw[i]};
                all_diff  = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (m_hist[i][j] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    new_rise[i] = ~m_stable[i];
                    m_stable[i] = ~m_stable[i];
                end
            end
            m_rise = new_rise;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, {bus.start_stop_raw, bus.btn_raw}, bus.req_clr);
        @(negedge clk);
        vectors += 4;
        assert (bus.req_pulse === m_pulse) else begin
            miscompares++;
            $error("FAIL req_pulse observed=%b expected=%b", bus.req_pulse, m_pulse);
        end
        assert (bus.req_pending === m_pend) else begin
            miscompares++;
            $error("FAIL req_pending observed=%b expected=%b", bus.req_pending, m_pend);
        end
        assert (bus.run === m_run) else begin
            miscompares++;
            $error("FAIL run observed=%b expected=%b", bus.run, m_run);
        end
        assert (!$isunknown({bus.req_pulse, bus.req_pending, bus.run})) else begin
            miscompares++;
            $error("FAIL no_x observed=%b expected=no X", {bus.req_pulse, bus.req_pending, bus.run});
        end
    endtask

    // Step n cycles, noting the first pulse, first run change and pulse counts
    task automatic run_steps(input int n);
        logic run0;
        run0          = bus.run;
        first_pulse_k = 0;
        first_pulse_v = '0;
        first_run_k   = 0;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (first_pulse_k == 0 && bus.req_pulse != 4'b0000) begin
                first_pulse_k = k;
                first_pulse_v = bus.req_pulse;
            end
            if (first_run_k == 0 && bus.run !== run0) first_run_k = k;
            for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(bus.req_pulse[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_ss();
        bus.start_stop_raw = 1'b1;
        run_steps(10);
        bus.start_stop_raw = 1'b0;
        run_steps(10);
    endtask

    int         hold_left [5];
    logic [4:0] rnd_raw;

    initial begin
        for (int i = 0; i < 5; i++) m_hist[i] = '0;
        m_stable = '0; m_rise = '0; m_run = 1'b0; m_pend = '0; m_pulse = '0;
        rst = 1'b1;
        bus.btn_raw = '0;
        bus.start_stop_raw = 1'b0;
        bus.req_clr = '0;
        @(negedge clk);

        // Reset and clean start/stop press
        run_steps(3);
        chk("reset_run", 32'(bus.run), 32'd0);
        chk("reset_pending", 32'(bus.req_pending), 32'd0);
        rst = 1'b0;
        bus.start_stop_raw = 1'b1;
        run_steps(10);
        chk("run_latency", first_run_k, 32'd7);
        chk("run_on", 32'(bus.run), 32'd1);
        bus.start_stop_raw = 1'b0;
        run_steps(10);

        // Clean up press
        bus.btn_raw = 4'b0001;
        run_steps(10);
        chk("up_latency", first_pulse_k, 32'd7);
        chk("up_pulse_val", 32'(first_pulse_v), 32'h1);
        chk("up_pending", 32'(bus.req_pending), 32'h1);
        bus.btn_raw = 4'b0000;
        run_steps(10);

        // Bounce rejection on down: 1,0,1,0 then hold
        bus.btn_raw = 4'b0010; run_steps(1);
        bus.btn_raw = 4'b0000; run_steps(1);
        bus.btn_raw = 4'b0010; run_steps(1);
        bus.btn_raw = 4'b0000; run_steps(1);
        bus.btn_raw = 4'b0010;
        run_steps(12);
        chk("bounce_latency", first_pulse_k, 32'd7);
        chk("bounce_count", pulse_cnt[1], 32'd1);
        bus.btn_raw = 4'b0000;
        bus.req_clr = 4'b1111; run_steps(1);
        bus.req_clr = 4'b0000; run_steps(1);
        chk("clr_all", 32'(bus.req_pending), 32'h0);
        run_steps(8);

        // Clear versus set on toTwo
        bus.btn_raw = 4'b1000; run_steps(10);
        bus.btn_raw = 4'b0000; run_steps(10);
        chk("to_two_pending", 32'(bus.req_pending), 32'h8);
        bus.req_clr = 4'b1000; run_steps(1);
        bus.req_clr = 4'b0000;
        chk("to_two_cleared", 32'(bus.req_pending), 32'h0);
        bus.btn_raw = 4'b1000; run_steps(6);
        bus.req_clr = 4'b1000; run_steps(1);
        bus.req_clr = 4'b0000;
        chk("collision_pulse", 32'(bus.req_pulse), 32'h8);
        chk("collision_pending", 32'(bus.req_pending), 32'h8);
        run_steps(3);
        bus.btn_raw = 4'b0000; run_steps(10);

        // Gating by run
        press_ss();
        chk("stop_run", 32'(bus.run), 32'd0);
        chk("stop_pending", 32'(bus.req_pending), 32'h0);
        bus.btn_raw = 4'b0100; run_steps(10);
        chk("gated_pulses", pulse_cnt[2], 32'd0);
        chk("gated_pending", 32'(bus.req_pending), 32'h0);
        bus.btn_raw = 4'b0000; run_steps(10);
        press_ss();
        chk("restart_run", 32'(bus.run), 32'd1);
        bus.btn_raw = 4'b0011; run_steps(10);
        chk("dual_pulse", 32'(first_pulse_v), 32'h3);
        chk("dual_pending", 32'(bus.req_pending), 32'h3);
        bus.btn_raw = 4'b0000; run_steps(10);

        // Hold without repeat
        bus.btn_raw = 4'b0001; run_steps(50);
        chk("hold_count", pulse_cnt[0], 32'd1);
        bus.btn_raw = 4'b0000; run_steps(10);
        bus.btn_raw = 4'b0001; run_steps(10);
        chk("repress_count", pulse_cnt[0], 32'd1);
        bus.btn_raw = 4'b0000; run_steps(10);

        // Reset mid-operation
        bus.req_clr = 4'b1111; run_steps(1);
        bus.req_clr = 4'b0000;
        bus.btn_raw = 4'b0101; run_steps(10);
        bus.btn_raw = 4'b0100; run_steps(10);
        chk("pre_reset_pending", 32'(bus.req_pending), 32'h5);
        rst = 1'b1; run_steps(1);
        chk("mid_reset_outputs", 32'({bus.req_pulse, bus.req_pending, bus.run}), 32'h0);
        rst = 1'b0; run_steps(15);
        chk("post_reset_pulses", pulse_cnt[2], 32'd0);
        chk("post_reset_run", 32'(bus.run), 32'd0);
        bus.btn_raw = 4'b0000; run_steps(10);

        // Randomised traffic against the model
        for (int i = 0; i < 5; i++) hold_left[i] = 0;
        rnd_raw = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (hold_left[i] == 0) begin
                    rnd_raw[i]   = 1'($urandom_range(0, 1));
                    hold_left[i] = (i == 4) ? int'($urandom_range(3, 30)) : int'($urandom_range(1, 12));
                end else begin
                    hold_left[i]--;
                end
            end
            bus.btn_raw        = rnd_raw[3:0];
            bus.start_stop_raw = rnd_raw[4];
            bus.req_clr        = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rst                = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        bus.req_clr = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_request_conditioner.md
# elevator_request_conditioner

Front-end stage of the two-floor elevator controller. It conditions the raw hall and car push-buttons and the start/stop key: synchronises and debounces them, turns each press into a single-cycle pulse, and holds each request until the elevator logic reports it serviced. It feeds the floor/state/LED logic stage directly downstream, replacing the raw button nets that stage would otherwise consume.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz). Legal values are ≥2.
- `clk_50mhz`  in  1: sole clock. The block uses rising edges only.
- `rst`  in  1: reset, synchronous and active-high.
- `btn_raw`  in  4: asynchronous raw buttons, active-high. Bit 0 is up, bit 1 is down, bit 2 is toOne, bit 3 is toTwo.
- `start_stop_raw`  in  1: asynchronous raw start/stop push-button, active-high.
- `req_clr`  in  4: per-request clear from downstream, sampled every cycle. Same bit map as `btn_raw`.
- `req_pending`  out  4: latched requests awaiting service, one per button.
- `req_pulse`  out  4: one-cycle strobe per accepted press.
- `run`  out  1: system enabled. Toggled by start/stop presses.

## Operation
- **Synchronisers:** each of the 5 raw inputs passes through a 2-flop synchroniser.
- **Debounce:** each synchronised input has a debounce cell holding `stable` and a counter.
  - Sync value equals `stable`: counter is held at 0.
  - Sync value differs from `stable`: counter increments.
  - Counter reaches `DEBOUNCE_CYCLES-1` while sync still differs: `stable` takes the sync value and the counter returns to 0.
  - Any glitch shorter than `DEBOUNCE_CYCLES` samples leaves `stable` unchanged.
- **Edge detect:** a rising edge on `stable` produces a registered one-cycle `rise` from the cell. A falling edge produces nothing.
- **run:**
  - Reset value is 0.
  - The start/stop `rise` toggles `run`.
  - On the cycle `run` goes 1→0, all `req_pending` bits clear.
- **Request bit i:**
  - `req_pulse[i]` = `rise[i]` & `run`. Presses while `run`=0 are discarded and do not pulse.
  - `req_pending[i]` next state:
    - `rst` → 0
    - else `run` falling → 0
    - else `req_pulse[i]` → 1 (a new press wins over a simultaneous `req_clr[i]`)
    - else `req_clr[i]` → 0
    - else hold.
  - Holding a button does not re-pulse. The button must be released (debounced low) and pressed again.
  - Several buttons may pulse in the same cycle. Bits are fully independent, and the block applies no priority between them; arbitration belongs downstream.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps, since it is cleared at the terminal count.

## Timing
- **Reset values:** all outputs, synchroniser flops, `stable` bits and counters go to 0 at the first rising edge with `rst`=1.
- **Press latency:** raw input held high from before clock edge E0 (first edge sampling 1) produces:
  - `req_pulse` high for exactly the cycle after edge E0+`DEBOUNCE_CYCLES`+2;
  - `req_pending` high from that same edge;
  - total latency `DEBOUNCE_CYCLES`+3 edges.
- **Release latency:** same figure, for the `stable` fall.
- **Clear latency:** `req_clr[i]` sampled at edge N drops `req_pending[i]` at edge N. Visible the following cycle.
- **run latency:** `run` changes on the same edge `req_pulse` would assert for a hall button.
- **Reset mid-debounce:** counters are discarded. A button still held after reset is treated as a new press, with full latency counted from the reset release.

## Structure
- **Shared package `elevator_pkg`:**
  - `N_BTN`=4
  - index constants `BTN_UP`=0, `BTN_DOWN`=1, `BTN_TO_ONE`=2, `BTN_TO_TWO`=3
  - `DEBOUNCE_CYCLES_DEFAULT`=1000000
  - the downstream stage imports the same package.
- **Sub-module `debounce_cell`:** synchroniser, counter, `stable` and `rise`. Parameter `DEBOUNCE_CYCLES`. Instantiated 5 times.
- **Top level:** `run` toggle and pending/pulse logic only.

## Test plan
Benches run with `DEBOUNCE_CYCLES`=4.
- **Reset and clean press:** hold `rst` 3 cycles, then release. Assert start/stop clean high for 10 cycles → `run`=1 at edge 7 after first sampled 1. Then press up clean → `req_pulse`=4'b0001 for one cycle 7 edges later and `req_pending`=4'b0001 held.
- **Bounce rejection:** with `run`=1, toggle `btn_raw[1]` 1,0,1,0 on successive cycles, then hold 1 → exactly one `req_pulse[1]`, 7 edges after the final rise. No earlier pulse.
- **Clear vs. set collision:** pending toTwo. Assert `req_clr[3]` → bit clears next cycle. Repeat with `req_clr[3]` coinciding with a new `req_pulse[3]` → `req_pending[3]` stays 1.
- **Gating by run:** with `run`=0, press toOne → no pulse and `req_pending`=0. Set `run`=1 and latch up+down together → `req_pulse`=4'b0011 in the same cycle. Press start/stop → `run`=0 and `req_pending`=4'b0000.
- **Hold without repeat:** hold up for 50 cycles → one pulse only. Release ≥4 cycles, press again → second pulse.
- **Reset mid-operation:** assert `rst` with `btn_raw[2]` held and pending 4'b0101 → all outputs 0 next cycle. After release, `run` stays 0, so no pulse. Check no `X` anywhere.
